// File: rtl/axi_pkg.sv
// Shared types for the AXI write responder: burst/response encodings, FSM states
// and the AW buffer entry layout.
package axi_pkg;

    localparam int DEF_AXI_DW = 128;
    localparam int DEF_AXI_AW = 32;
    localparam int DEF_AXI_IW = 8;
    localparam int DEF_AXI_LW = 8;
    localparam int DEF_L      = $clog2(DEF_AXI_DW / 8);

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wr_state_e;

    // err is resolved at push time so the FSM never looks at burst/size again
    typedef struct packed {
        logic [DEF_AXI_IW-1:0]          id;
        logic [DEF_AXI_AW-DEF_L-1:0]    addr;
        logic [DEF_AXI_LW-1:0]          len;
        logic                           incr;
        logic                           err;
    } aw_entry_t;

    function automatic logic aw_unsupported(input logic [1:0] burst,
                                            input logic [2:0] size,
                                            input int unsigned l);
        return !((burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR))
               || (int'(size) != int'(l));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + (do_push ? 1'b1 : 1'b0);
        rd_ptr_d = rd_ptr_q + (do_pop ? 1'b1 : 1'b0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/axi_wr_responder.sv
// AXI write slave: buffers AW bursts, splits them into per-beat user-port writes,
// checks WLAST against AWLEN and returns one B response per burst.
//
// state | meaning
// IDLE  | no burst in service, waiting for the AW buffer to fill
// DATA  | accepting W beats for the current burst (written, or drained on err)
// RESP  | B response held until bready
module axi_wr_responder
    import axi_pkg::*;
#(
    parameter int AXI_DW     = DEF_AXI_DW,
    parameter int AXI_AW     = DEF_AXI_AW,
    parameter int AXI_IW     = DEF_AXI_IW,
    parameter int AXI_LW     = DEF_AXI_LW,
    parameter int AXI_SW     = 3,
    parameter int AXI_BURSTW = 2,
    parameter int AXI_BRESPW = 2,
    parameter int AMI_AD     = 4,
    parameter int AXI_BYTES  = AXI_DW / 8,
    parameter int L          = $clog2(AXI_BYTES)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [AXI_IW-1:0]     awid,
    input  logic [AXI_AW-1:0]     awaddr,
    input  logic [AXI_LW-1:0]     awlen,
    input  logic [AXI_SW-1:0]     awsize,
    input  logic [AXI_BURSTW-1:0] awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [AXI_DW-1:0]     wdata,
    input  logic [AXI_BYTES-1:0]  wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [AXI_IW-1:0]     bid,
    output logic [AXI_BRESPW-1:0] bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  usr_wvalid,
    input  logic                  usr_wready,
    output logic [AXI_AW-1:0]     usr_waddr,
    output logic [AXI_DW-1:0]     usr_wdata,
    output logic [AXI_BYTES-1:0]  usr_wstrb
);

    aw_entry_t push_entry;
    aw_entry_t head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      pop;

    wr_state_e             state_q, state_d;
    logic [AXI_IW-1:0]     cur_id_q, cur_id_d;
    logic [AXI_AW-L-1:0]   cur_addr_q, cur_addr_d;
    logic [AXI_LW-1:0]     cur_len_q, cur_len_d;
    logic                  cur_incr_q, cur_incr_d;
    logic                  cur_err_q, cur_err_d;
    logic [AXI_LW:0]       beat_cnt_q, beat_cnt_d;
    logic                  bvalid_q, bvalid_d;
    logic [AXI_IW-1:0]     bid_q, bid_d;
    logic [AXI_BRESPW-1:0] bresp_q, bresp_d;
    logic                  beat;
    logic                  early_last;

    assign awready = reset_n && !fifo_full;
    assign push    = awvalid && awready;

    always_comb begin
        push_entry      = '0;
        push_entry.id   = awid;
        push_entry.addr = awaddr[AXI_AW-1:L];
        push_entry.len  = awlen;
        push_entry.incr = (awburst == AXI_BURST_INCR);
        push_entry.err  = aw_unsupported(awburst, awsize, L);
    end

    sync_fifo #(
        .WIDTH ($bits(aw_entry_t)),
        .DEPTH (AMI_AD)
    ) u_aw_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The user port is a straight pass-through of W while a legal burst is in DATA
    assign wready     = (state_q == ST_DATA) && (cur_err_q || usr_wready);
    assign usr_wvalid = (state_q == ST_DATA) && !cur_err_q && wvalid;
    assign usr_waddr  = {cur_addr_q, {L{1'b0}}};
    assign usr_wdata  = wdata;
    assign usr_wstrb  = wstrb;
    assign bvalid     = bvalid_q;
    assign bid        = bid_q;
    assign bresp      = bresp_q;

    always_comb begin
        state_d    = state_q;
        cur_id_d   = cur_id_q;
        cur_addr_d = cur_addr_q;
        cur_len_d  = cur_len_q;
        cur_incr_d = cur_incr_q;
        cur_err_d  = cur_err_q;
        beat_cnt_d = beat_cnt_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        pop        = 1'b0;
        beat       = (state_q == ST_DATA) && wvalid && wready;
        early_last = beat_cnt_q < {1'b0, cur_len_q};

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    if (!cur_err_q) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        if (cur_incr_q) begin
                            cur_addr_d = cur_addr_q + 1'b1;
                        end
                    end
                    if (wlast) begin
                        state_d  = ST_RESP;
                        bvalid_d = 1'b1;
                        bid_d    = cur_id_q;
                        bresp_d  = (cur_err_q || early_last) ? RESP_SLVERR : RESP_OKAY;
                    end else if (!early_last) begin
                        cur_err_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                    pop      = !fifo_empty;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            state_d    = ST_DATA;
            cur_id_d   = head.id;
            cur_addr_d = head.addr;
            cur_len_d  = head.len;
            cur_incr_d = head.incr;
            cur_err_d  = head.err;
            beat_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cur_id_q   <= '0;
            cur_addr_q <= '0;
            cur_len_q  <= '0;
            cur_incr_q <= 1'b0;
            cur_err_q  <= 1'b0;
            beat_cnt_q <= '0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_id_q   <= cur_id_d;
            cur_addr_q <= cur_addr_d;
            cur_len_q  <= cur_len_d;
            cur_incr_q <= cur_incr_d;
            cur_err_q  <= cur_err_d;
            beat_cnt_q <= beat_cnt_d;
            bvalid_q   <= bvalid_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
        end
    end

endmodule

// File: doc/axi_wr_responder.md
Name: axi_wr_responder

Overview:
- Slave-side AXI write responder. It sits at the far end of the AW/W/B channels driven by the DMA burst-issue logic.
- Accepts AW bursts into a small buffer and decodes each burst into per-beat word writes on a simple user memory port.
- Checks WLAST against AWLEN and generates one B response per burst, with BID = AWID and OKAY or SLVERR.

Parameters:
- AXI_DW, 128, AXI data bus width
- AXI_AW, 32, AXI address width (<= 32)
- AXI_IW, 8, ID width
- AXI_LW, 8, AWLEN width
- AXI_SW, 3, AWSIZE width
- AXI_BURSTW, 2, AWBURST width
- AXI_BRESPW, 2, BRESP width
- AMI_AD, 4, AW buffer depth (power of 2, >= 2)
- AXI_BYTES, AXI_DW/8, derived, bytes per beat
- L, $clog2(AXI_BYTES), derived, byte-offset bits

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- awid  in  AXI_IW  write ID
- awaddr  in  AXI_AW  byte start address
- awlen  in  AXI_LW  beats-1
- awsize  in  AXI_SW  beat size
- awburst  in  AXI_BURSTW  burst type
- awvalid  in  1  AW valid
- awready  out  1  AW ready = AW buffer not full
- wdata  in  AXI_DW  write data
- wstrb  in  AXI_BYTES  byte strobes
- wlast  in  1  last beat
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  AXI_IW  response ID
- bresp  out  AXI_BRESPW  0=OKAY, 2=SLVERR
- bvalid  out  1  B valid
- bready  in  1  B ready
- usr_wvalid  out  1  user write strobe
- usr_wready  in  1  user write accept
- usr_waddr  out  AXI_AW  word-aligned byte address, low L bits 0
- usr_wdata  out  AXI_DW  = wdata
- usr_wstrb  out  AXI_BYTES  = wstrb

Behaviour:
- Reset values: awready 0 while reset_n low, then 1 (buffer empty); wready 0; bvalid 0; bid 0; bresp 0; usr_wvalid 0; usr_waddr 0; FSM in IDLE; buffer emptied.
- AW buffer: AW is pushed on awvalid&awready. Push and pop in the same cycle are allowed while full, but awready stays low when full.
- FSM states IDLE, DATA, RESP:
  - IDLE: if buffer not empty, pop the head and load cur_id, cur_addr (awaddr[AW-1:L]), beat_cnt=0, cur_len=awlen. Set err=1 if awburst is not INCR(1) or FIXED(0), or if awsize != L. Then go to DATA. Pop-to-DATA latency is 1 cycle.
  - DATA, normal (err=0):
    - usr_wvalid = wvalid; wready = usr_wready; a beat completes on wvalid&wready.
    - Per beat: INCR increments cur_addr by 1 word, FIXED holds it; beat_cnt increments.
    - Address wraps modulo 2^(AXI_AW-L); no 4KB check.
  - DATA, drain (err=1): usr_wvalid = 0; wready = 1; beats are discarded.
  - Early wlast: wlast with beat_cnt < cur_len sets err, and the burst ends at that beat. That beat is still written if err was 0.
  - Missing wlast: final beat (beat_cnt == cur_len) with wlast=0 is written, then err is set and the block drains until wlast.
  - Burst end: the beat with wlast=1 goes to RESP. On entry, bvalid=1, bid=cur_id, bresp = err ? 2'b10 : 2'b00.
  - RESP: hold bvalid, bid and bresp stable until bready. Exit on bvalid&bready: to DATA (head popped and loaded the same cycle) if buffer not empty, else IDLE. bvalid drops the next cycle unless re-asserted.
- W beats arriving before AW are not accepted (wready=0 outside DATA).
- At most one burst is in DATA/RESP at a time. AW acceptance continues up to AMI_AD entries.
- Width rule: beat_cnt is AXI_LW+1 bits so awlen=255 does not overflow.
- Reset mid-burst: all state is cleared immediately. The outstanding B is lost, and the master is reset together with this block.

Decomposition:
- Shared package axi_pkg:
  - enum for AXI_BURST_FIXED/INCR/WRAP
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - aw_entry_t struct {id, addr[AW-1:L], len, err}, with err precomputed at push
- Sub-module sync_fifo (parameters WIDTH, DEPTH), used as the AW buffer: push/pop/full/empty, first-word-fall-through, async active-low reset.

Test Plan:
- AW id=5, addr=0x1000, len=3, INCR, size=4; 4 beats with wlast on beat 4, usr_wready=1 -> usr_waddr 0x1000, 0x1010, 0x1020, 0x1030; then bvalid with bid=5, bresp=0.
- Same burst with usr_wready toggling 1/0 -> wready mirrors usr_wready; exactly 4 user writes; addresses unchanged from above.
- len=3 with wlast on beat 2 -> 2 writes, bresp=2; next queued burst proceeds normally.
- len=1 with wlast only on beat 4 -> 2 writes, beats 3–4 drained, bresp=2.
- awburst=WRAP, len=7 -> 0 user writes, 8 beats drained, bresp=2, bid matches awid.
- 6 AW pushed back-to-back, bready held 0 -> awready low after 4 buffered plus 1 in service. Then bready=1 -> 6 responses in AW order, bids 0..5.
